// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding the ALU: GPR file, operand selection with
// writeback bypass, valid/ready output register with held-operand refresh and flush.
module alu_operand_stage #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_instruction,
  output logic [XLEN-1:0]         out_regA,
  output logic [XLEN-1:0]         out_regB,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic [31:0]             issue_count
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] gpr_q [NREG];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] rega_q, rega_d;
  logic [XLEN-1:0] regb_q, regb_d;
  logic [AW-1:0]   srca_q, srca_d;
  logic [AW-1:0]   srcb_q, srcb_d;
  logic [31:0]     issue_count_q, issue_count_d;

  logic [5:0]      opcode_s;
  logic [5:0]      funct_s;
  logic [AW-1:0]   rs_s;
  logic [AW-1:0]   rt_s;
  logic            is_shift_s;
  logic [AW-1:0]   sel_a_s;
  logic [AW-1:0]   sel_b_s;
  logic [XLEN-1:0] rd_a_s;
  logic [XLEN-1:0] rd_b_s;
  logic            wb_hit_s;
  logic            capture_s;
  logic            accept_s;
  logic            hold_s;

  assign opcode_s  = in_instruction[31:26];
  assign funct_s   = in_instruction[5:0];
  assign rs_s      = in_instruction[25:21];
  assign rt_s      = in_instruction[20:16];
  assign wb_hit_s  = wb_en && (wb_addr != {AW{1'b0}});

  assign in_ready  = !out_valid_q || out_ready;
  assign capture_s = in_valid && in_ready && !flush;
  assign accept_s  = out_valid_q && out_ready;
  assign hold_s    = out_valid_q && !out_ready && !capture_s && !flush;

  // Shift instructions present the shifted value (rt) as regA
  always_comb begin
    is_shift_s = 1'b0;
    if (opcode_s == 6'b000000) begin
      case (funct_s)
        6'b000000, 6'b000010, 6'b000011,
        6'b000100, 6'b000110, 6'b000111: is_shift_s = 1'b1;
        default:                         is_shift_s = 1'b0;
      endcase
    end else begin
      is_shift_s = 1'b0;
    end
    sel_a_s = is_shift_s ? rt_s : rs_s;
    sel_b_s = is_shift_s ? rs_s : rt_s;
  end

  // Register read with r0 forced to zero and same-cycle writeback bypass
  always_comb begin
    rd_a_s = {XLEN{1'b0}};
    rd_b_s = {XLEN{1'b0}};
    if (sel_a_s == {AW{1'b0}}) begin
      rd_a_s = {XLEN{1'b0}};
    end else if (wb_hit_s && (wb_addr == sel_a_s)) begin
      rd_a_s = wb_data;
    end else begin
      rd_a_s = gpr_q[sel_a_s];
    end
    if (sel_b_s == {AW{1'b0}}) begin
      rd_b_s = {XLEN{1'b0}};
    end else if (wb_hit_s && (wb_addr == sel_b_s)) begin
      rd_b_s = wb_data;
    end else begin
      rd_b_s = gpr_q[sel_b_s];
    end
  end

  // Output register next state: capture, drain, flush and held-operand refresh
  always_comb begin
    out_valid_d   = out_valid_q;
    inst_d        = inst_q;
    rega_d        = rega_q;
    regb_d        = regb_q;
    srca_d        = srca_q;
    srcb_d        = srcb_q;
    issue_count_d = accept_s ? (issue_count_q + 32'd1) : issue_count_q;
    if (capture_s) begin
      out_valid_d = 1'b1;
      inst_d      = in_instruction;
      rega_d      = rd_a_s;
      regb_d      = rd_b_s;
      srca_d      = sel_a_s;
      srcb_d      = sel_b_s;
    end else if (flush || accept_s) begin
      out_valid_d = 1'b0;
    end else if (hold_s && wb_hit_s) begin
      rega_d = (wb_addr == srca_q) ? wb_data : rega_q;
      regb_d = (wb_addr == srcb_q) ? wb_data : regb_q;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output bundle and issue counter state
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      inst_q        <= {XLEN{1'b0}};
      rega_q        <= {XLEN{1'b0}};
      regb_q        <= {XLEN{1'b0}};
      srca_q        <= {AW{1'b0}};
      srcb_q        <= {AW{1'b0}};
      issue_count_q <= 32'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      inst_q        <= inst_d;
      rega_q        <= rega_d;
      regb_q        <= regb_d;
      srca_q        <= srca_d;
      srcb_q        <= srcb_d;
      issue_count_q <= issue_count_d;
    end
  end

  // General-purpose register file; entry 0 is never written
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= {XLEN{1'b0}};
      end
    end else if (wb_hit_s) begin
      gpr_q[wb_addr] <= wb_data;
    end else begin
      gpr_q[0] <= {XLEN{1'b0}};
    end
  end

  assign out_valid       = out_valid_q;
  assign out_instruction = inst_q;
  assign out_regA        = rega_q;
  assign out_regB        = regb_q;
  assign issue_count     = issue_count_q;

endmodule
